// File: rtl/led_mode_ctrl_if.sv
// Board-pin bundle for led_mode_ctrl: raw switch/button inputs and LED-side outputs.
interface led_mode_ctrl_if;
    logic [3:0] sw;
    logic       mode_btn;
    logic [3:0] leds;
    logic       user_led;
    logic [1:0] mode;
    logic       tick;

    modport master (
        output sw,
        output mode_btn,
        input  leds,
        input  user_led,
        input  mode,
        input  tick
    );

    modport slave (
        input  sw,
        input  mode_btn,
        output leds,
        output user_led,
        output mode,
        output tick
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// Switch/button conditioning, mode FSM (pass/chase/blink) and heartbeat for the
// board LED path.
module led_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 160000,
    parameter int unsigned TICK_CYCLES     = 1600000,
    parameter int unsigned HEARTBEAT_TICKS = 5
) (
    input logic         clk,
    input logic         rst_n,
    led_mode_ctrl_if.slave bus
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TW = $clog2(TICK_CYCLES);
    localparam int unsigned HW = (HEARTBEAT_TICKS > 1) ? $clog2(HEARTBEAT_TICKS) : 1;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_CHASE = 2'b01,
        MODE_BLINK = 2'b10
    } mode_t;

    logic [3:0]    sw_meta, sw_sync, sw_prev, sw_stable;
    logic          btn_meta, btn_sync, btn_prev, btn_stable, btn_stable_q;
    logic [DW-1:0] sw_cnt, btn_cnt;
    logic [TW-1:0] presc_cnt;
    logic [HW-1:0] hb_cnt;
    logic          tick, btn_evt;
    mode_t         state;
    logic [3:0]    chase;
    logic          blink_phase;
    logic [3:0]    leds_q;
    logic          user_led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            sw_prev  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            sw_meta  <= bus.sw;
            sw_sync  <= sw_meta;
            sw_prev  <= sw_sync;
            btn_meta <= bus.mode_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // Accepting on the counting step that would reach DEBOUNCE_CYCLES-1 gives
    // a pin-to-stable latency of DEBOUNCE_CYCLES+2 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable <= '0;
            sw_cnt    <= '0;
        end else if (sw_sync == sw_stable) begin
            sw_cnt <= '0;
        end else if (sw_sync != sw_prev) begin
            sw_cnt <= '0;
        end else if (sw_cnt == DW'(DEBOUNCE_CYCLES - 2)) begin
            sw_stable <= sw_sync;
            sw_cnt    <= '0;
        end else begin
            sw_cnt <= sw_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_stable   <= 1'b0;
            btn_stable_q <= 1'b0;
            btn_cnt      <= '0;
        end else begin
            btn_stable_q <= btn_stable;
            if (btn_sync == btn_stable) begin
                btn_cnt <= '0;
            end else if (btn_sync != btn_prev) begin
                btn_cnt <= '0;
            end else if (btn_cnt == DW'(DEBOUNCE_CYCLES - 2)) begin
                btn_stable <= btn_sync;
                btn_cnt    <= '0;
            end else begin
                btn_cnt <= btn_cnt + 1'b1;
            end
        end
    end

    assign btn_evt = btn_stable & ~btn_stable_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (presc_cnt == TW'(TICK_CYCLES - 1)) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    assign tick = (presc_cnt == TW'(TICK_CYCLES - 1));

    // Mode entry outranks a coincident tick; the heartbeat still sees every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MODE_PASS;
            chase       <= 4'b0001;
            blink_phase <= 1'b0;
            leds_q      <= '0;
            user_led_q  <= 1'b0;
            hb_cnt      <= '0;
        end else begin
            if (tick) begin
                if (hb_cnt == HW'(HEARTBEAT_TICKS - 1)) begin
                    hb_cnt     <= '0;
                    user_led_q <= ~user_led_q;
                end else begin
                    hb_cnt <= hb_cnt + 1'b1;
                end
            end

            if (btn_evt) begin
                case (state)
                    MODE_PASS: begin
                        state <= MODE_CHASE;
                        chase <= 4'b0001;
                    end
                    MODE_CHASE: begin
                        state       <= MODE_BLINK;
                        blink_phase <= 1'b1;
                    end
                    default: state <= MODE_PASS;
                endcase
            end else begin
                case (state)
                    MODE_PASS:  ;
                    MODE_CHASE: if (tick) chase <= {chase[2:0], chase[3]};
                    MODE_BLINK: if (tick) blink_phase <= ~blink_phase;
                    default:    state <= MODE_PASS;
                endcase
            end

            case (state)
                MODE_PASS:  leds_q <= sw_stable;
                MODE_CHASE: leds_q <= chase;
                MODE_BLINK: leds_q <= sw_stable & {4{blink_phase}};
                default:    leds_q <= '0;
            endcase
        end
    end

    assign bus.leds     = leds_q;
    assign bus.user_led = user_led_q;
    assign bus.mode     = state;
    assign bus.tick     = tick;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl: debounce vector table plus hand sequences
// for mode cycling, blink, tick/heartbeat timing, collisions and async reset.
module tb_led_mode_ctrl;
    localparam int unsigned DEB = 4;
    localparam int unsigned TCK = 8;
    localparam int unsigned HB  = 2;

    logic        tb_clk = 1'b0;
    logic        rst_n  = 1'b0;
    int unsigned total  = 0;
    int unsigned bad    = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [3:0]  sw;
        int unsigned hold;
        logic [3:0]  exp;
        bit          steady;
    } vec_t;

    vec_t vecs [9];

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_CYCLES    (TCK),
        .HEARTBEAT_TICKS(HB)
    ) dut (
        .clk  (tb_clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 tb_clk = ~tb_clk;

    // Cycles since reset release; the prescaler phase is cyc mod TCK.
    always @(posedge tb_clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge tb_clk) begin
        check("tick", {3'b000, bus.tick}, {3'b000, (cyc % TCK) == TCK - 1});
        check("user_led", {3'b000, bus.user_led}, {3'b000, ((cyc / (TCK * HB)) % 2) == 1});
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic align(input int unsigned r);
        int unsigned guard;
        guard = 0;
        @(negedge tb_clk);
        while ((cyc % TCK) != r && guard < 16) begin
            @(negedge tb_clk);
            guard++;
        end
    endtask

    task automatic press();
        bus.mode_btn = 1'b1;
        step(10);
        bus.mode_btn = 1'b0;
    endtask

    task automatic wait_change(input logic [3:0] last, output logic [3:0] val, output int unsigned at);
        int unsigned k;
        k = 0;
        do begin
            step(1);
            k++;
        end while (bus.leds === last && k < 20);
        val = bus.leds;
        at  = cyc;
    endtask

    initial begin
        logic [3:0]  val;
        logic [3:0]  last;
        logic [3:0]  chase_exp [4];
        int unsigned at, prev_at;

        vecs[0] = '{4'b0000,  6, 4'b1111, 1'b0};
        vecs[1] = '{4'b0000,  1, 4'b0000, 1'b0};
        vecs[2] = '{4'b0101,  2, 4'b0000, 1'b1};
        vecs[3] = '{4'b0000,  1, 4'b0000, 1'b1};
        vecs[4] = '{4'b0101,  6, 4'b0000, 1'b1};
        vecs[5] = '{4'b0101,  1, 4'b0101, 1'b0};
        vecs[6] = '{4'b1111,  3, 4'b0101, 1'b1};
        vecs[7] = '{4'b0101, 10, 4'b0101, 1'b1};
        vecs[8] = '{4'b1010,  7, 4'b1010, 1'b0};
        chase_exp[0] = 4'b0010;
        chase_exp[1] = 4'b0100;
        chase_exp[2] = 4'b1000;
        chase_exp[3] = 4'b0001;

        bus.sw       = 4'b1111;
        bus.mode_btn = 1'b0;

        // Reset with switches high
        step(4);
        check("rst_leds", bus.leds, 4'b0000);
        check("rst_user_led", {3'b000, bus.user_led}, 4'b0000);
        check("rst_mode", {2'b00, bus.mode}, 4'b0000);
        check("rst_tick", {3'b000, bus.tick}, 4'b0000);
        rst_n = 1'b1;
        step(6);
        check("rel_leds_early", bus.leds, 4'b0000);
        step(1);
        check("rel_leds", bus.leds, 4'b1111);

        // Debounce table in PASS
        for (int unsigned i = 0; i < 9; i++) begin
            bus.sw = vecs[i].sw;
            for (int unsigned c = 0; c < vecs[i].hold; c++) begin
                step(1);
                if (vecs[i].steady) check($sformatf("vec%0d_hold", i), bus.leds, vecs[i].exp);
            end
            check($sformatf("vec%0d", i), bus.leds, vecs[i].exp);
            check($sformatf("vec%0d_mode", i), {2'b00, bus.mode}, 4'b0000);
        end

        // PASS -> CHASE, then four rotations one tick apart
        align(2);
        press();
        check("chase_mode", {2'b00, bus.mode}, 4'b0001);
        check("chase_entry", bus.leds, 4'b0001);
        last    = 4'b0001;
        prev_at = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            wait_change(last, val, at);
            check($sformatf("chase_step%0d", i), val, chase_exp[i]);
            check_int($sformatf("chase_phase%0d", i), at % TCK, 1);
            if (i > 0) check_int($sformatf("chase_gap%0d", i), at - prev_at, TCK);
            prev_at = at;
            last    = val;
        end
        check("chase_release_no_evt", {2'b00, bus.mode}, 4'b0001);

        // CHASE -> BLINK with sw=1010
        align(2);
        press();
        check("blink_mode", {2'b00, bus.mode}, 4'b0010);
        check("blink_entry", bus.leds, 4'b1010);
        wait_change(4'b1010, val, at);
        check("blink_off", val, 4'b0000);
        check_int("blink_off_phase", at % TCK, 1);
        prev_at = at;
        wait_change(4'b0000, val, at);
        check("blink_on", val, 4'b1010);
        check_int("blink_gap", at - prev_at, TCK);

        // BLINK -> PASS
        press();
        check("pass_mode", {2'b00, bus.mode}, 4'b0000);
        check("pass_leds", bus.leds, 4'b1010);

        // Button event lands on a tick cycle while entering CHASE
        align(1);
        press();
        check("coll_mode", {2'b00, bus.mode}, 4'b0001);
        check("coll_leds", bus.leds, 4'b0001);
        step(5);
        check("coll_leds_hold", bus.leds, 4'b0001);

        // Async reset between edges mid-CHASE
        @(negedge tb_clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mode", {2'b00, bus.mode}, 4'b0000);
        check("arst_leds", bus.leds, 4'b0000);
        check("arst_tick", {3'b000, bus.tick}, 4'b0000);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post_rst_mode", {2'b00, bus.mode}, 4'b0000);
        step(6);
        check("post_rst_leds", bus.leds, 4'b1010);
        press();
        check("post_rst_to_chase", {2'b00, bus.mode}, 4'b0001);
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
